sync_detector_param: RTL and testbench



---
 rtl/sync_pkg.sv | 23 ++
 rtl/sync_err_counter.sv | 21 ++
 rtl/sync_detector_param.sv | 134 +++++++++++++
 tb/tb_sync_detector_param.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for the sync detector: line-state encodings, FSM states
// and the expected-symbol function for the K,J...K,K sync pattern.
package sync_pkg;

  // {k,j} line-state encodings
  localparam logic [1:0] SYM_K   = 2'b10;
  localparam logic [1:0] SYM_J   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;
  localparam logic [1:0] SYM_INV = 2'b11;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    MATCH  = 2'd1,
    SYNCED = 2'd2
  } state_e;

  // Symbol expected at pattern index p: K,J pairs first, then the closing K,K.
  function automatic logic [1:0] exp_sym(input int p, input int pairs);
    if (p >= 2 * pairs) return SYM_K;
    return (p % 2 == 0) ? SYM_K : SYM_J;
  endfunction

endpackage

// File: rtl/sync_err_counter.sv
// Saturating event counter for sync errors; cleared only by reset.
module sync_err_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count error pulses, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst)                       cnt_q <= '0;
    else if (inc_i && ~&cnt_q)     cnt_q <= cnt_q + CNT_W'(1);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sync_detector_param.sv
// Parametrised line synchroniser: hunts for SYNC_PAIRS x (K,J) then K,K,
// holds lock until an SE0 run of EOP_LEN or an invalid line state.
// Optional build macro SYNC_ERR_CNT_EN adds a saturating sync-error counter
// on err_cnt; without it err_cnt is tied to zero.
module sync_detector_param
  import sync_pkg::*;
#(
  parameter int SYNC_PAIRS = 3,
  parameter int EOP_LEN    = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             k,
  input  logic             j,
  input  logic             rx_en,
  output logic             synced_d,
  output logic             sync_err_d,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int L     = 2 * SYNC_PAIRS + 2;
  localparam int POS_W = $clog2(L + 1);
  localparam int EOP_W = $clog2(EOP_LEN + 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(L - 1);
  localparam logic [EOP_W-1:0] EOP_LAST = EOP_W'(EOP_LEN - 1);

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [EOP_W-1:0] eop_q, eop_d;
  logic             lock_q, lock_d;
  logic             perr_q, perr_d;
  logic [1:0]       sym;

  assign sym = {k, j};

  // State, position, EOP run and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      pos_q   <= '0;
      eop_q   <= '0;
      lock_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      eop_q   <= eop_d;
      lock_q  <= lock_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state decode; nothing moves unless a symbol is presented.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    eop_d   = eop_q;
    lock_d  = lock_q;
    perr_d  = 1'b0;
    if (rx_en) begin
      unique case (state_q)
        HUNT: begin
          if (sym == SYM_K) begin
            state_d = MATCH;
            pos_d   = POS_W'(1);
          end
        end
        MATCH: begin
          if (sym == exp_sym(int'(pos_q), SYNC_PAIRS)) begin
            if (pos_q == POS_LAST) begin
              state_d = SYNCED;
              lock_d  = 1'b1;
              pos_d   = '0;
              eop_d   = '0;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            perr_d = 1'b1;
            // A stray K can itself start a fresh pattern.
            if (sym == SYM_K) begin
              pos_d = POS_W'(1);
            end else begin
              state_d = HUNT;
              pos_d   = '0;
            end
          end
        end
        SYNCED: begin
          // INV is checked first so it wins over EOP counting.
          if (sym == SYM_INV) begin
            perr_d  = 1'b1;
            state_d = HUNT;
            lock_d  = 1'b0;
            eop_d   = '0;
          end else if (sym == SYM_SE0) begin
            if (eop_q == EOP_LAST) begin
              state_d = HUNT;
              lock_d  = 1'b0;
              eop_d   = '0;
            end else begin
              eop_d = eop_q + EOP_W'(1);
            end
          end else begin
            eop_d = '0;
          end
        end
        default: begin
          state_d = HUNT;
          pos_d   = '0;
          eop_d   = '0;
          lock_d  = 1'b0;
        end
      endcase
    end
  end

  assign synced_d   = lock_q;
  assign sync_err_d = perr_q;

`ifdef SYNC_ERR_CNT_EN
  // Counter steps on the same edge that registers the error pulse.
  sync_err_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (perr_d),
    .cnt_o (err_cnt)
  );
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sync_detector_param.sv
// Directed bench for sync_detector_param (default pattern K,J,K,J,K,J,K,K).
module tb_sync_detector_param;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             k = 1'b0, j = 1'b0, rx_en = 1'b0;
  logic             synced_d, sync_err_d;
  logic [CNT_W-1:0] err_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_detector_param #(.SYNC_PAIRS(3), .EOP_LEN(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .k          (k),
    .j          (j),
    .rx_en      (rx_en),
    .synced_d   (synced_d),
    .sync_err_d (sync_err_d),
    .err_cnt    (err_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Present one cycle of input, then settle just past the edge.
  task automatic step(input logic [1:0] s, input logic en);
    {k, j} = s;
    rx_en  = en;
    @(posedge clk);
    #1;
  endtask

  // Expected err_cnt after n error pulses since reset.
  function automatic int expc(input int n);
`ifdef SYNC_ERR_CNT_EN
    return (n > 3) ? 3 : n;
`else
    return 0;
`endif
  endfunction

  logic [1:0] pat [8];
  logic [1:0] s2  [7];

  initial begin
    pat = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
    s2  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10};

    // reset
    step(2'b00, 1'b0);
    step(2'b00, 1'b0);
    chk("rst_synced", synced_d, 0);
    chk("rst_err", sync_err_d, 0);
    chk("rst_cnt", err_cnt, 0);
    rst = 1'b0;

    // 1: clean pattern locks after the 8th symbol
    for (int i = 0; i < 8; i++) begin
      step(pat[i], 1'b1);
      chk($sformatf("p1_synced%0d", i), synced_d, (i == 7) ? 1 : 0);
      chk($sformatf("p1_err%0d", i), sync_err_d, 0);
    end

    // 3: SE0,J,SE0,SE0 -> J clears the run, drop after the final SE0
    step(2'b00, 1'b1); chk("eop_se0a", synced_d, 1);
    step(2'b01, 1'b1); chk("eop_j", synced_d, 1);
    step(2'b00, 1'b1); chk("eop_se0b", synced_d, 1);
    step(2'b00, 1'b0); chk("eop_gap", synced_d, 1);
    step(2'b00, 1'b1); chk("eop_drop", synced_d, 0);
    chk("eop_noerr", sync_err_d, 0);

    // 2: K,J,K,K -> error on the 4th, then restart from pos 1
    step(2'b10, 1'b1);
    step(2'b01, 1'b1);
    step(2'b10, 1'b1); chk("mm_pre", sync_err_d, 0);
    step(2'b10, 1'b1);
    chk("mm_pulse", sync_err_d, 1);
    chk("mm_synced", synced_d, 0);
    chk("mm_cnt", err_cnt, expc(1));
    for (int i = 0; i < 7; i++) begin
      step(s2[i], 1'b1);
      chk($sformatf("mm_err%0d", i), sync_err_d, 0);
      chk($sformatf("mm_synced%0d", i), synced_d, (i == 6) ? 1 : 0);
    end

    // 4: INV while locked -> pulse and unlock together
    step(2'b11, 1'b1);
    chk("inv_err", sync_err_d, 1);
    chk("inv_synced", synced_d, 0);
    chk("inv_cnt", err_cnt, expc(2));
    step(2'b11, 1'b0);
    chk("inv_pulse_end", sync_err_d, 0);

    // HUNT ignores J, SE0, INV silently
    step(2'b01, 1'b1); chk("hunt_j", sync_err_d, 0);
    step(2'b00, 1'b1); chk("hunt_se0", sync_err_d, 0);
    step(2'b11, 1'b1); chk("hunt_inv", sync_err_d, 0);

    // 5: gapped pattern locks only after the last symbol
    for (int i = 0; i < 8; i++) begin
      step(pat[i], 1'b1);
      chk($sformatf("gap_sym%0d", i), synced_d, (i == 7) ? 1 : 0);
      for (int g = 0; g <= i % 3; g++) begin
        step(2'b11, 1'b0);
        chk($sformatf("gap_hold%0d_%0d", i, g), synced_d, (i == 7) ? 1 : 0);
        chk($sformatf("gap_err%0d_%0d", i, g), sync_err_d, 0);
      end
    end

    // reset mid-pattern: outputs clear, no pulse, pattern restarts from scratch
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
    step(2'b10, 1'b1);
    step(2'b01, 1'b1);
    step(2'b10, 1'b1);
    rst = 1'b1;
    step(2'b01, 1'b1);
    chk("rst_mid_synced", synced_d, 0);
    chk("rst_mid_err", sync_err_d, 0);
    chk("rst_mid_cnt", err_cnt, 0);
    rst = 1'b0;
    step(2'b01, 1'b1);
    chk("rst_mid_hunt", sync_err_d, 0);
    for (int i = 0; i < 8; i++) begin
      step(pat[i], 1'b1);
      chk($sformatf("relock%0d", i), synced_d, (i == 7) ? 1 : 0);
    end

    // 6: five mismatches from fresh reset -> counter saturates
    rst = 1'b1;
    step(2'b00, 1'b0);
    rst = 1'b0;
    step(2'b10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(2'b10, 1'b1);
      chk($sformatf("cnt_err%0d", i), sync_err_d, 1);
      chk($sformatf("cnt_val%0d", i), err_cnt, expc(i + 1));
    end
    step(2'b00, 1'b0);
    chk("cnt_hold", err_cnt, expc(5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
